one_state_controller: RTL and testbench

- One-hot multicycle FSM controller for the multicycle CPU.
- Takes the 6-bit opcode from the instruction register and drives all datapath control strobes: PC, memory, IR, register file, ALU muxes and ALU operation.
- Outputs are Moore-style, decoded from the current state, with no combinational path from OPcode to outputs.

---
 rtl/one_state_controller.sv | 113 +++++++++++
 tb/tb_one_state_controller.sv | 127 ++++++++++++
 2 files changed

// File: rtl/one_state_controller.sv
// one_state_controller: one-hot multicycle CPU control FSM with Moore outputs decoded from state.
// Define ONESTATE_JUMP_EN to build the JUMP state (opcode 110000); otherwise that opcode is a NOP.
module one_state_controller (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] OPcode,
    output logic       PCWriteCond,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       BEQ,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSrc,
    output logic [3:0] ALUOP,
    output logic [1:0] ALUSrcB
);
    localparam int FETCH   = 0;
    localparam int DECODE  = 1;
    localparam int EXEC_R  = 2;
    localparam int RWB     = 3;
    localparam int EXEC_I  = 4;
    localparam int IWB     = 5;
    localparam int MEMADDR = 6;
    localparam int MEMRD   = 7;
    localparam int MEMWB   = 8;
    localparam int MEMWR   = 9;
    localparam int BRANCH  = 10;
    localparam int JUMP    = 11;
    localparam logic [5:0] OP_LW   = 6'b111011;
    localparam logic [5:0] OP_SW   = 6'b111100;
    localparam logic [5:0] OP_JUMP = 6'b110000;
`ifdef ONESTATE_JUMP_EN
    localparam bit JumpEn = 1'b1;
`else
    localparam bit JumpEn = 1'b0;
`endif

    logic [11:0] state, nextState, s;
    logic [5:0]  op;
    logic        legal, jmp;

    assign legal = (state != '0) && ((state & (state - 12'd1)) == '0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= 12'd1 << FETCH;
            op    <= '0;
        end else begin
            state <= nextState;
            if (legal && state[DECODE])
                op <= OPcode;
        end
    end

    // DECODE steers on the live opcode; every later state uses the latched op
    always_comb begin
        nextState = '0;
        if (!legal)
            nextState[FETCH] = 1'b1;
        else if (state[FETCH])
            nextState[DECODE] = 1'b1;
        else if (state[DECODE]) begin
            if (OPcode[5:4] == 2'b00)
                nextState[EXEC_R] = 1'b1;
            else if (OPcode[5:4] == 2'b01)
                nextState[EXEC_I] = 1'b1;
            else if (OPcode[5:1] == 5'b10000)
                nextState[BRANCH] = 1'b1;
            else if (OPcode == OP_LW || OPcode == OP_SW)
                nextState[MEMADDR] = 1'b1;
            else if (JumpEn && OPcode == OP_JUMP)
                nextState[JUMP] = 1'b1;
            else
                nextState[FETCH] = 1'b1;
        end
        else if (state[EXEC_R])
            nextState[RWB] = 1'b1;
        else if (state[EXEC_I])
            nextState[IWB] = 1'b1;
        else if (state[MEMADDR])
            nextState[op == OP_LW ? MEMRD : MEMWR] = 1'b1;
        else if (state[MEMRD])
            nextState[MEMWB] = 1'b1;
        else
            nextState[FETCH] = 1'b1;
    end

    // held reset presents FETCH outputs; an illegal vector decodes to all zeros
    always_comb begin
        s           = !reset ? 12'd1 << FETCH : legal ? state : '0;
        jmp         = JumpEn & s[JUMP];
        PCWriteCond = s[BRANCH];
        PCWrite     = s[FETCH] | jmp;
        IorD        = s[MEMRD] | s[MEMWR];
        MemRead     = s[FETCH] | s[MEMRD];
        MemWrite    = s[MEMWR];
        MemtoReg    = s[MEMWB];
        IRWrite     = s[FETCH];
        BEQ         = s[BRANCH] & ~op[0];
        ALUSrcA     = s[EXEC_R] | s[EXEC_I] | s[MEMADDR] | s[BRANCH];
        RegWrite    = s[RWB] | s[IWB] | s[MEMWB];
        RegDst      = s[RWB];
        PCSrc       = s[BRANCH] ? 2'b01 : jmp ? 2'b10 : 2'b00;
        ALUOP       = (s[EXEC_R] | s[EXEC_I]) ? op[3:0] : s[BRANCH] ? 4'b0001 : 4'b0000;
        ALUSrcB     = s[FETCH] ? 2'b01 : s[DECODE] ? 2'b11 :
                      (s[EXEC_I] | s[MEMADDR]) ? 2'b10 : 2'b00;
    end
endmodule

// File: tb/tb_one_state_controller.sv
// tb_one_state_controller: directed per-cycle checks of every control output for each instruction class.
module tb_one_state_controller;
    logic       clock, reset;
    logic [5:0] OPcode;
    logic       PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic       BEQ, ALUSrcA, RegWrite, RegDst;
    logic [1:0] PCSrc, ALUSrcB;
    logic [3:0] ALUOP;
    logic [18:0] outs;
    int errors = 0;
    int checks = 0;

    one_state_controller dut (
        .clock(clock), .reset(reset), .OPcode(OPcode),
        .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .BEQ(BEQ), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSrc(PCSrc), .ALUOP(ALUOP), .ALUSrcB(ALUSrcB)
    );

    assign outs = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                   BEQ, ALUSrcA, RegWrite, RegDst, PCSrc, ALUOP, ALUSrcB};

    // fields: pcwc pcw iord mr mw m2r irw beq asa rw rd pcsrc aluop alusrcb
    localparam logic [18:0] F    = {7'b0101001, 4'b0000, 2'b00, 4'h0, 2'b01};
    localparam logic [18:0] D    = {7'b0000000, 4'b0000, 2'b00, 4'h0, 2'b11};
    localparam logic [18:0] MA   = {7'b0000000, 4'b0100, 2'b00, 4'h0, 2'b10};
    localparam logic [18:0] MR   = {7'b0011000, 4'b0000, 2'b00, 4'h0, 2'b00};
    localparam logic [18:0] MWB  = {7'b0000010, 4'b0010, 2'b00, 4'h0, 2'b00};
    localparam logic [18:0] MW   = {7'b0010100, 4'b0000, 2'b00, 4'h0, 2'b00};
    localparam logic [18:0] EI3  = {7'b0000000, 4'b0100, 2'b00, 4'h3, 2'b10};
    localparam logic [18:0] IWB  = {7'b0000000, 4'b0010, 2'b00, 4'h0, 2'b00};
    localparam logic [18:0] BRZ  = {7'b1000000, 4'b1100, 2'b01, 4'h1, 2'b00};
    localparam logic [18:0] BRNZ = {7'b1000000, 4'b0100, 2'b01, 4'h1, 2'b00};
    localparam logic [18:0] ER0  = {7'b0000000, 4'b0100, 2'b00, 4'h0, 2'b00};
    localparam logic [18:0] ER5  = {7'b0000000, 4'b0100, 2'b00, 4'h5, 2'b00};
    localparam logic [18:0] RWB  = {7'b0000000, 4'b0011, 2'b00, 4'h0, 2'b00};
    localparam logic [18:0] JMP  = {7'b0100000, 4'b0000, 2'b10, 4'h0, 2'b00};

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%b want=%b", tag, got, want);
        end
    endtask

    // drive OPcode for this cycle, check outputs, advance to 1ns after the next edge
    task automatic step(input string tag, input logic [18:0] want, input logic [5:0] opc);
        OPcode = opc;
        check(tag, outs, want);
        @(posedge clock);
        #1;
    endtask

    initial begin
        clock  = 1'b0;
        reset  = 1'b0;
        OPcode = 6'b111011;
        #1;
        check("rst_t0", outs, F);
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            check("rst_hold", outs, F);
        end
        reset = 1'b1;
        // LW with OPcode scrambled after DECODE
        step("lw_fetch", F, 6'b000000);
        step("lw_decode", D, 6'b111011);
        step("lw_memaddr", MA, 6'b111100);
        step("lw_memrd", MR, 6'b000000);
        step("lw_memwb", MWB, 6'b100000);
        // SW
        step("sw_fetch", F, 6'b000000);
        step("sw_decode", D, 6'b111100);
        step("sw_memaddr", MA, 6'b111011);
        step("sw_memwr", MW, 6'b010000);
        // I-type opcode 19
        step("i_fetch", F, 6'b000000);
        step("i_decode", D, 6'd19);
        step("i_exec", EI3, 6'b000101);
        step("i_wb", IWB, 6'b000000);
        // branch on zero, then on nonzero
        step("beq_fetch", F, 6'b000000);
        step("beq_decode", D, 6'd32);
        step("beq_branch", BRZ, 6'd33);
        step("bne_fetch", F, 6'b000000);
        step("bne_decode", D, 6'd33);
        step("bne_branch", BRNZ, 6'd32);
        // R-type opcodes 0 and 5
        step("r0_fetch", F, 6'b111011);
        step("r0_decode", D, 6'd0);
        step("r0_exec", ER0, 6'b010011);
        step("r0_wb", RWB, 6'b000000);
        step("r5_fetch", F, 6'b000000);
        step("r5_decode", D, 6'b000101);
        step("r5_exec", ER5, 6'b000000);
        step("r5_wb", RWB, 6'b000000);
        // unknown opcode is a 2-cycle NOP
        step("nop_fetch", F, 6'b000000);
        step("nop_decode", D, 6'b101010);
        step("j_fetch", F, 6'b000000);
        step("j_decode", D, 6'b110000);
`ifdef ONESTATE_JUMP_EN
        step("j_jump", JMP, 6'b000000);
`endif
        // reset asserted mid-LW aborts to FETCH
        step("ab_fetch", F, 6'b000000);
        step("ab_decode", D, 6'b111011);
        step("ab_memaddr", MA, 6'b000000);
        check("ab_memrd", outs, MR);
        reset = 1'b0;
        #1;
        check("ab_rst_comb", outs, F);
        @(posedge clock);
        #1;
        reset = 1'b1;
        step("ab_after_fetch", F, 6'b000000);
        step("ab_after_decode", D, 6'b101010);
        check("final_fetch", outs, F);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
